interface_out: RTL and testbench
================================

# interface_out

Result write-back block for the matrix coprocessor: the store-side counterpart of the operand-fetch path. It accepts result matrix elements one byte at a time from the coprocessor, packs them two per 16-bit word (low byte first), and writes the words to consecutive data-memory addresses starting at a base address. A `done` pulse marks the end of the job.

## Interface
Parameters: none. Widths are fixed: 8-bit elements, 16-bit memory words, 8-bit word addresses.

Ports (name, direction, width, meaning):
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a write-back job; sampled only in IDLE.
- `size` in 2: matrix dimension; 00=2x2, 01=3x3, 10=4x4, 11=5x5.
- `base_addr` in 8: word address of the first result word.
- `elem_data` in 8: result element from the coprocessor.
- `elem_valid` in 1: `elem_data` is valid.
- `elem_ready` out 1: block can accept an element this cycle.
- `mem_addr` out 8: memory write address.
- `mem_wdata` out 16: memory write data, `{hi_elem, lo_elem}`.
- `mem_we` out 1: memory write strobe, one cycle per word.
- `busy` out 1: job in progress (any state other than IDLE).
- `done` out 1: one-cycle pulse at end of job.

## Operation
- Element count N: 4, 9, 16 or 25. Word count W = ceil(N/2): 2, 5, 8 or 13.
- States:
  - IDLE: no job in progress.
  - ACC_LO: accepting the low byte of a word.
  - ACC_HI: accepting the high byte of a word.
  - WRITE: issuing the memory write.
  - DONE: signalling job completion.
- IDLE: when `start`=1, latch `size` and `base_addr`, clear the element and word counters, and go to ACC_LO.
- ACC_LO: `elem_ready`=1.
  - A transfer occurs when `elem_valid && elem_ready`; store the element as the low byte.
  - If this was element N-1 (odd N), set the high byte to 0x00 and go to WRITE; otherwise go to ACC_HI.
  - With no transfer, hold state.
- ACC_HI: `elem_ready`=1. On a transfer, store the high byte and go to WRITE.
- WRITE: `elem_ready`=0 and `mem_we`=1 for exactly one cycle.
  - `mem_addr` = (latched base + word index) mod 256; address wrap-around is silent.
  - `mem_wdata` = {hi, lo}.
  - Increment the word index. If word index+1 = W, go to DONE; otherwise go to ACC_LO.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` asserted in any state other than IDLE is ignored. Latched `size`/`base_addr` do not change mid-job.
- `elem_data` is sampled only on a transfer cycle. When not accepting, `elem_valid` is ignored.
- Outside WRITE, `mem_addr` and `mem_wdata` hold their last values; only `mem_we` qualifies a write.

## Timing
- Reset values: state=IDLE, `elem_ready`=0, `mem_we`=0, `busy`=0, `done`=0, `mem_addr`=0x00, `mem_wdata`=0x0000.
- Reset mid-job: the block returns to IDLE on the next edge. No further `mem_we` is issued and no `done` pulse is produced. The partially written words are left as-is.
- With `start` in cycle 0, `elem_ready` and `busy` are high from cycle 1.
- With `elem_valid` held high, each word takes 3 cycles (LO, HI, WRITE). An odd final word takes 2 cycles (LO, WRITE).
- With `elem_valid` held high, `done` is high in cycle 1+3W for even N and in cycle 3W for odd N:
  - 2x2: cycle 7.
  - 3x3: cycle 15.
  - 4x4: cycle 25.
  - 5x5: cycle 39.
- `busy` falls in the cycle after `done`. A new `start` is accepted in that same cycle (back-to-back jobs allowed).
- Stalls (`elem_valid`=0) extend the ACC states only. There is no timeout.

## Test plan
- Reset then idle: after `rst`, all outputs are at their reset values. Pulsing `elem_valid` with `start`=0 produces no `mem_we`.
- 2x2, base 0x10, elements 0x01..0x04 streamed continuously:
  - writes 0x0201 @0x10 and 0x0403 @0x11;
  - `done` in cycle 7;
  - exactly 2 `mem_we` pulses.
- 3x3, base 0x20, elements 0x11..0x19: 5 writes to 0x20..0x24, the last being 0x0019 @0x24; `done` in cycle 15.
- 5x5, base 0xFA, elements 0..24 with `elem_valid` toggling every other cycle:
  - 13 writes, addresses 0xFA..0xFF then wrapping to 0x00..0x06;
  - data is correct regardless of stalls.
- Mid-job `start` and reset, 4x4 job:
  - a `start` pulse in ACC_HI changes nothing;
  - `rst` asserted after the 3rd write gives no further `mem_we` and no `done`;
  - a following 2x2 job completes normally.
- Back-to-back: a second `start` in the cycle after `done`, with a different base, begins a correct new job. No write from the second job appears before its first WRITE state.

Source files
------------

// File: rtl/interface_out.sv
// Result write-back: packs 8-bit matrix elements two per 16-bit word (low byte
// first) and writes the words to consecutive memory addresses from a base.
module interface_out (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [7:0]  base_addr,
    input  logic [7:0]  elem_data,
    input  logic        elem_valid,
    output logic        elem_ready,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACC_LO = 3'd1,
        ST_ACC_HI = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t      state_r;
    logic [1:0]  size_r;
    logic [7:0]  base_r;
    logic [4:0]  elem_cnt_r;
    logic [3:0]  word_idx_r;
    logic [7:0]  lo_r;
    logic        elem_ready_r;
    logic [7:0]  mem_addr_r;
    logic [15:0] mem_wdata_r;
    logic        mem_we_r;
    logic        busy_r;
    logic        done_r;

    logic        transfer_s;
    logic        last_elem_s;
    logic        last_word_s;
    logic [7:0]  write_addr_s;

    function automatic logic [4:0] elem_total(input logic [1:0] sz);
        logic [4:0] n;
        case (sz)
            2'd0:    n = 5'd4;
            2'd1:    n = 5'd9;
            2'd2:    n = 5'd16;
            2'd3:    n = 5'd25;
            default: n = 5'd4;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] word_total(input logic [1:0] sz);
        logic [3:0] w;
        case (sz)
            2'd0:    w = 4'd2;
            2'd1:    w = 4'd5;
            2'd2:    w = 4'd8;
            2'd3:    w = 4'd13;
            default: w = 4'd2;
        endcase
        return w;
    endfunction

    // Handshake and end-of-job decodes from the latched job parameters.
    always_comb begin
        transfer_s   = elem_valid && elem_ready_r;
        last_elem_s  = (elem_cnt_r == (elem_total(size_r) - 5'd1));
        last_word_s  = ((word_idx_r + 4'd1) == word_total(size_r));
        write_addr_s = base_r + {4'd0, word_idx_r};
    end

    // Job sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            size_r       <= 2'd0;
            base_r       <= 8'd0;
            elem_cnt_r   <= 5'd0;
            word_idx_r   <= 4'd0;
            lo_r         <= 8'd0;
            elem_ready_r <= 1'b0;
            mem_addr_r   <= 8'd0;
            mem_wdata_r  <= 16'd0;
            mem_we_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_we_r <= 1'b0;
                    done_r   <= 1'b0;
                    if (start) begin
                        size_r       <= size;
                        base_r       <= base_addr;
                        elem_cnt_r   <= 5'd0;
                        word_idx_r   <= 4'd0;
                        elem_ready_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_ACC_LO;
                    end else begin
                        elem_ready_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end
                ST_ACC_LO: begin
                    if (transfer_s) begin
                        lo_r       <= elem_data;
                        elem_cnt_r <= elem_cnt_r + 5'd1;
                        if (last_elem_s) begin
                            // Odd element count: final word carries a zero high byte.
                            mem_addr_r   <= write_addr_s;
                            mem_wdata_r  <= {8'h00, elem_data};
                            mem_we_r     <= 1'b1;
                            elem_ready_r <= 1'b0;
                            state_r      <= ST_WRITE;
                        end else begin
                            state_r <= ST_ACC_HI;
                        end
                    end else begin
                        state_r <= ST_ACC_LO;
                    end
                end
                ST_ACC_HI: begin
                    if (transfer_s) begin
                        elem_cnt_r   <= elem_cnt_r + 5'd1;
                        mem_addr_r   <= write_addr_s;
                        mem_wdata_r  <= {elem_data, lo_r};
                        mem_we_r     <= 1'b1;
                        elem_ready_r <= 1'b0;
                        state_r      <= ST_WRITE;
                    end else begin
                        state_r <= ST_ACC_HI;
                    end
                end
                ST_WRITE: begin
                    mem_we_r   <= 1'b0;
                    word_idx_r <= word_idx_r + 4'd1;
                    if (last_word_s) begin
                        elem_ready_r <= 1'b0;
                        done_r       <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        elem_ready_r <= 1'b1;
                        state_r      <= ST_ACC_LO;
                    end
                end
                ST_DONE: begin
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    elem_ready_r <= 1'b0;
                    mem_we_r     <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    elem_ready_r <= 1'b0;
                    mem_we_r     <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign elem_ready = elem_ready_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_we     = mem_we_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_interface_out.sv
// Self-checking bench for interface_out: each job is compared against a
// word-level model of the expected writes, addresses and done timing.
module tb_interface_out;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  size;
    logic [7:0]  base_addr;
    logic [7:0]  elem_data;
    logic        elem_valid;
    logic        elem_ready;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;
    logic [7:0] elems [25];

    interface_out dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .size       (size),
        .base_addr  (base_addr),
        .elem_data  (elem_data),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one job starting in the current cycle (caller is at posedge+1).
    // mode: 0 = elem_valid held high, 1 = toggling, 2 = random stalls.
    task automatic run_job(input logic [1:0] sz, input logic [7:0] bs, input int mode,
                           input int glitch_cyc, input int rst_cyc, input string name);
        int n, w, k, idx, done_cnt, done_at, limit, wexp, acc;
        bit finished, v;
        logic [7:0]  exp_addr [13];
        logic [15:0] exp_data [13];
        int          exp_cyc  [13];
        int          exp_done;
        logic [7:0]  got_addr [$];
        logic [15:0] got_data [$];
        int          got_cyc  [$];

        n = (int'(sz) + 2) * (int'(sz) + 2);
        w = (n + 1) / 2;
        acc = 0;
        for (int j = 0; j < w; j++) begin
            exp_addr[j] = bs + 8'(j);
            exp_data[j] = {(2 * j + 1 < n) ? elems[2 * j + 1] : 8'h00, elems[2 * j]};
            acc = acc + ((2 * j + 1 < n) ? 3 : 2);
            exp_cyc[j] = acc;
        end
        exp_done = acc + 1;

        k = 0; idx = 0; done_cnt = 0; done_at = -1; finished = 1'b0;
        limit = (rst_cyc > 0) ? rst_cyc + 15 : 400;
        start = 1'b1; size = sz; base_addr = bs; elem_valid = 1'b0; elem_data = 8'($urandom);
        while (!finished && k <= limit) begin
            if (k > 0) begin
                start = (k == glitch_cyc);
                size = 2'($urandom);
                base_addr = 8'($urandom);
                rst = (k == rst_cyc);
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (k % 2 == 1);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                if (idx >= n) v = 1'b0;
                elem_valid = v;
                elem_data = v ? elems[idx] : 8'($urandom);
            end
            @(negedge clk);
            if (elem_valid && elem_ready && !rst) idx++;
            if (mem_we) begin
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_wdata);
                got_cyc.push_back(k);
            end
            if (done) begin
                done_cnt++;
                done_at = k;
                if (rst_cyc == 0) finished = 1'b1;
            end
            if (k == 1) begin
                n_checks++;
                if (busy !== 1'b1 || elem_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy/ready in cycle 1: got %b/%b want 1/1", name, busy, elem_ready);
                end
            end
            if (rst_cyc > 0 && k == rst_cyc + 1) begin
                n_checks++;
                if (busy !== 1'b0 || elem_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 ||
                    mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL %s after mid-job reset: busy=%b ready=%b we=%b done=%b addr=%h wdata=%h want all zero",
                             name, busy, elem_ready, mem_we, done, mem_addr, mem_wdata);
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0; rst = 1'b0; elem_valid = 1'b0;

        if (rst_cyc == 0) begin
            n_checks++;
            if (!finished) begin
                n_fail++;
                $display("FAIL %s timeout: no done within %0d cycles", name, limit);
            end
        end

        wexp = w;
        if (rst_cyc > 0) begin
            wexp = 0;
            for (int j = 0; j < w; j++) if (exp_cyc[j] <= rst_cyc) wexp++;
        end
        n_checks++;
        if (got_addr.size() != wexp) begin
            n_fail++;
            $display("FAIL %s write count: got %0d want %0d", name, got_addr.size(), wexp);
        end
        for (int j = 0; j < wexp && j < got_addr.size(); j++) begin
            n_checks++;
            if (got_addr[j] !== exp_addr[j] || got_data[j] !== exp_data[j]) begin
                n_fail++;
                $display("FAIL %s word %0d: got %h@%h want %h@%h", name, j,
                         got_data[j], got_addr[j], exp_data[j], exp_addr[j]);
            end
            if (mode == 0) begin
                n_checks++;
                if (got_cyc[j] != exp_cyc[j]) begin
                    n_fail++;
                    $display("FAIL %s word %0d cycle: got %0d want %0d", name, j, got_cyc[j], exp_cyc[j]);
                end
            end
        end
        n_checks++;
        if (done_cnt != ((rst_cyc > 0) ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s done pulses: got %0d want %0d", name, done_cnt, (rst_cyc > 0) ? 0 : 1);
        end
        if (mode == 0 && rst_cyc == 0) begin
            n_checks++;
            if (done_at != exp_done) begin
                n_fail++;
                $display("FAIL %s done cycle: got %0d want %0d", name, done_at, exp_done);
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0 || elem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle after done: busy=%b done=%b we=%b ready=%b want 0", name, busy, done, mem_we, elem_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; size = 2'd0; base_addr = 8'h00;
        elem_data = 8'h00; elem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (elem_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset values: ready=%b we=%b busy=%b done=%b addr=%h wdata=%h want zeros",
                     elem_ready, mem_we, busy, done, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            elem_valid = ~elem_valid;
            elem_data = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if (mem_we !== 1'b0 || elem_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL idle valid pulse: we=%b ready=%b want 0/0", mem_we, elem_ready);
            end
        end
        @(posedge clk);
        #1;
        elem_valid = 1'b0;
    endtask

    task automatic test_2x2();
        for (int i = 0; i < 4; i++) elems[i] = 8'(i + 1);
        run_job(2'd0, 8'h10, 0, 0, 0, "2x2");
        check_idle("2x2");
    endtask

    task automatic test_3x3();
        for (int i = 0; i < 9; i++) elems[i] = 8'(8'h11 + i);
        run_job(2'd1, 8'h20, 0, 0, 0, "3x3");
        check_idle("3x3");
    endtask

    task automatic test_5x5_stall();
        for (int i = 0; i < 25; i++) elems[i] = 8'(i);
        run_job(2'd3, 8'hFA, 1, 0, 0, "5x5_wrap_stall");
        check_idle("5x5_wrap_stall");
    endtask

    task automatic test_midjob();
        for (int i = 0; i < 25; i++) elems[i] = 8'($urandom);
        run_job(2'd2, 8'($urandom), 0, 2, 10, "4x4_start_rst");
        for (int i = 0; i < 25; i++) elems[i] = 8'($urandom);
        run_job(2'd0, 8'($urandom), 0, 0, 0, "2x2_after_rst");
        check_idle("2x2_after_rst");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 25; i++) elems[i] = 8'($urandom);
        run_job(2'd1, 8'h40, 0, 0, 0, "b2b_first");
        for (int i = 0; i < 25; i++) elems[i] = 8'($urandom);
        run_job(2'd2, 8'hC3, 0, 0, 0, "b2b_second");
        check_idle("b2b_second");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 25; i++) elems[i] = 8'($urandom);
            run_job(2'($urandom), 8'($urandom), (t < 2) ? 0 : 2, 0, 0, "random");
        end
        check_idle("random");
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_2x2();
        test_3x3();
        test_5x5_stall();
        test_midjob();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
